// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
// The timebase mode encoding lives here so the top level and any
// register/control logic that drives it agree on one definition.
package pwm_pkg;

    // Width of the mode request field.
    localparam int MODE_W = 2;

    // Timebase counting modes. The fourth code (2'b11) is reserved and
    // never stored; it is folded into PWM_UP by mode_decode().
    typedef enum logic [MODE_W-1:0] {
        PWM_UP   = 2'b00,
        PWM_DOWN = 2'b01,
        PWM_UPDN = 2'b10
    } mode_t;

    // Map a raw requested mode onto a legal mode; reserved code runs as UP.
    function automatic mode_t mode_decode(input logic [MODE_W-1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = PWM_DOWN;
            2'b10:   m = PWM_UPDN;
            default: m = PWM_UP;
        endcase
        return m;
    endfunction

endpackage : pwm_pkg

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: holds the active compare value (reloaded only on the
// commit strobe from the timebase) and produces the registered,
// polarity-adjusted output bit. The output lags the timebase by one clock.
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk50m,
    input  logic         rst_n,
    input  logic         i_load,   // commit strobe at a period boundary
    input  logic [W-1:0] i_cmp,    // requested compare value
    input  logic [W-1:0] i_cnt,    // shared timebase value
    input  logic         i_pol,    // live output inversion
    output logic         o_pwm
);

    logic [W-1:0] r_cmp_act;
    logic         r_pwm;
    logic         w_active;

    // Active level while the timebase is below the compare value, so
    // compare 0 never fires and compare > period always fires.
    assign w_active = (i_cnt < r_cmp_act);

    // Active compare register: only changes on a committed update.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_act <= '0;
        end else if (i_load) begin
            r_cmp_act <= i_cmp;
        end
    end

    // Output register: evaluated every clock, even while the timebase holds.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_active ^ i_pol;
        end
    end

    assign o_pwm = r_pwm;

endmodule : pwm_cmp_ch

// File: rtl/pwm_multi.sv
// N-channel PWM generator sharing one W-bit timebase. The timebase counts
// up, down or up/down; mode, period and compares are double-buffered and
// only committed at a period boundary, so a reprogram never truncates a
// pulse. pe marks each boundary, upd_ack confirms each commit.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic           clk50m,
    input  logic           rst_n,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [W-1:0]   per,
    input  logic [N*W-1:0] cmp,
    input  logic [N-1:0]   pol,
    input  logic           upd_req,
    output logic [W-1:0]   cnt,
    output logic           dir,
    output logic [N-1:0]   pwm,
    output logic           pe,
    output logic           upd_ack
);

    localparam logic [W-1:0] L_ZERO = '0;
    localparam logic [W-1:0] L_ONE  = {{(W-1){1'b0}}, 1'b1};

    // Active (committed) configuration and timebase state.
    mode_t        r_mode_act;
    logic [W-1:0] r_per_act;
    logic [W-1:0] r_cnt;
    logic         r_dir;
    logic         r_pending;
    logic         r_pe;
    logic         r_upd_ack;

    // Combinational next-state terms.
    logic         w_terminal;
    logic         w_boundary;
    logic         w_commit;
    mode_t        w_mode_sel;
    logic [W-1:0] w_per_sel;
    logic [W-1:0] w_cnt_next;
    logic         w_dir_next;
    logic         w_pending_next;

    // Terminal count of the active mode. A zero period is terminal in
    // every mode, which pins the counter at zero without wrapping.
    // NOTE: every always_comb output gets a default first so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        w_terminal = 1'b0;
        case (r_mode_act)
            PWM_UP:   w_terminal = (r_cnt == r_per_act);
            PWM_DOWN: w_terminal = (r_cnt == L_ZERO);
            PWM_UPDN: w_terminal = ((r_cnt == L_ZERO) && r_dir) || (r_per_act == L_ZERO);
            default:  w_terminal = (r_cnt == r_per_act);
        endcase
    end

    // A boundary only happens while advancing; a commit needs a boundary
    // plus either a stored request or one arriving this very cycle.
    assign w_boundary = en & w_terminal;
    assign w_commit   = w_boundary & (r_pending | upd_req);

    // Configuration that governs the period starting after this edge.
    assign w_mode_sel = w_commit ? mode_decode(mode) : r_mode_act;
    assign w_per_sel  = w_commit ? per : r_per_act;

    // Timebase next state: restart at a boundary, otherwise step by mode.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (w_boundary) begin
            w_dir_next = 1'b0;
            case (w_mode_sel)
                PWM_UP:   w_cnt_next = L_ZERO;
                PWM_DOWN: w_cnt_next = w_per_sel;
                PWM_UPDN: w_cnt_next = (w_per_sel == L_ZERO) ? L_ZERO : L_ONE;
                default:  w_cnt_next = L_ZERO;
            endcase
        end else if (en) begin
            case (r_mode_act)
                PWM_UP: begin
                    w_cnt_next = r_cnt + L_ONE;
                end
                PWM_DOWN: begin
                    w_cnt_next = r_cnt - L_ONE;
                end
                PWM_UPDN: begin
                    if (!r_dir) begin
                        // Turn around at the peak so the peak value
                        // appears for exactly one cycle.
                        if (r_cnt == r_per_act) begin
                            w_dir_next = 1'b1;
                            w_cnt_next = r_per_act - L_ONE;
                        end else begin
                            w_cnt_next = r_cnt + L_ONE;
                        end
                    end else begin
                        w_cnt_next = r_cnt - L_ONE;
                    end
                end
                default: begin
                    w_cnt_next = r_cnt + L_ONE;
                end
            endcase
        end
    end

    // Pending request: set by upd_req, cleared only by the commit it causes.
    always_comb begin
        w_pending_next = r_pending;
        if (w_commit) begin
            w_pending_next = 1'b0;
        end else if (upd_req) begin
            w_pending_next = 1'b1;
        end
    end

    // Timebase, direction and pending-request registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_dir     <= w_dir_next;
            r_pending <= w_pending_next;
        end
    end

    // Active configuration registers, reloaded only on a commit.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_act <= PWM_UP;
            r_per_act  <= '0;
        end else if (w_commit) begin
            r_mode_act <= w_mode_sel;
            r_per_act  <= w_per_sel;
        end
    end

    // Single-cycle status pulses in the cycle after the boundary edge.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_pe      <= 1'b0;
            r_upd_ack <= 1'b0;
        end else begin
            r_pe      <= w_boundary;
            r_upd_ack <= w_commit;
        end
    end

    // One compare channel per output, all sharing the commit strobe.
    for (genvar g = 0; g < N; g++) begin : g_ch
        pwm_cmp_ch #(
            .W(W)
        ) u_ch (
            .clk50m (clk50m),
            .rst_n  (rst_n),
            .i_load (w_commit),
            .i_cmp  (cmp[g*W +: W]),
            .i_cnt  (r_cnt),
            .i_pol  (pol[g]),
            .o_pwm  (pwm[g])
        );
    end

    assign cnt     = r_cnt;
    assign dir     = r_dir;
    assign pe      = r_pe;
    assign upd_ack = r_upd_ack;

endmodule : pwm_multi

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a phase-based reference model (position within the
// current period, mapped to the counter value the mode implies) is compared
// on every falling edge, plus directed literal expectations per scenario.
module tb_pwm_multi;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk50m = 1'b0;
    logic           rst_n  = 1'b1;
    logic           en     = 1'b0;
    logic [1:0]     mode   = 2'b00;
    logic [W-1:0]   per    = '0;
    logic [N*W-1:0] cmp    = '0;
    logic [N-1:0]   pol    = '0;
    logic           upd_req = 1'b0;
    logic [W-1:0]   cnt;
    logic           dir;
    logic [N-1:0]   pwm;
    logic           pe;
    logic           upd_ack;

    pwm_multi #(.W(W), .N(N)) dut (
        .clk50m  (clk50m),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .per     (per),
        .cmp     (cmp),
        .pol     (pol),
        .upd_req (upd_req),
        .cnt     (cnt),
        .dir     (dir),
        .pwm     (pwm),
        .pe      (pe),
        .upd_ack (upd_ack)
    );

    always #10 clk50m = ~clk50m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // mode 0=UP 1=DOWN 2=UPDN; phase = position within the current period.
    int       m_mode    = 0;
    int       m_per     = 0;
    int       m_phase   = 0;
    int       m_cmp[N]  = '{default: 0};
    bit       m_pending = 0;
    logic     e_pe      = 1'b0;
    logic     e_ack     = 1'b0;
    logic [N-1:0] e_pwm = '0;

    function automatic int period_len();
        if (m_mode == 2) return (m_per == 0) ? 1 : 2 * m_per;
        return m_per + 1;
    endfunction

    function automatic int exp_cnt();
        if (m_mode == 0) return m_phase;
        if (m_mode == 1) return m_per - m_phase;
        if (m_per == 0) return 0;
        return (m_phase < m_per) ? m_phase + 1 : 2 * m_per - 1 - m_phase;
    endfunction

    function automatic logic exp_dir();
        return (m_mode == 2) && (m_per != 0) && (m_phase >= m_per);
    endfunction

    always @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_per = 0; m_phase = 0; m_pending = 0;
            for (int i = 0; i < N; i++) m_cmp[i] = 0;
            e_pe = 0; e_ack = 0; e_pwm = '0;
        end else begin
            bit b;
            bit c;
            for (int i = 0; i < N; i++) e_pwm[i] = (exp_cnt() < m_cmp[i]) ^ pol[i];
            b = en && (m_phase == period_len() - 1);
            c = b && (m_pending || upd_req);
            e_pe  = b;
            e_ack = c;
            if (c) begin
                m_mode = (mode == 2'b11) ? 0 : int'(mode);
                m_per  = int'(per);
                for (int i = 0; i < N; i++) m_cmp[i] = int'(cmp[i*W +: W]);
                m_pending = 0;
            end else if (upd_req) begin
                m_pending = 1;
            end
            if (b) m_phase = 0;
            else if (en) m_phase = m_phase + 1;
        end
    end

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk50m) begin
        check("cnt", cnt, exp_cnt());
        check("dir", dir, exp_dir());
        check("pwm", pwm, e_pwm);
        check("pe", pe, e_pe);
        check("upd_ack", upd_ack, e_ack);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk50m);
    endtask

    task automatic set_cmp(input int c0, input int c1, input int c2, input int c3);
        cmp = {W'(c3), W'(c2), W'(c1), W'(c0)};
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            upd_req = 1'b0;
            if (upd_ack) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic wait_cnt(input int v, input string name);
        bit seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (cnt == W'(v)) begin
                seen = 1;
                break;
            end
            tick();
        end
        check(name, seen, 1);
    endtask

    int exp1[5]   = '{1, 2, 3, 4, 0};
    int exp2[4]   = '{2, 1, 0, 3};
    int exp2pe[4] = '{0, 0, 0, 1};
    int exp3[6]   = '{2, 3, 2, 1, 0, 1};
    int exp3d[6]  = '{0, 0, 1, 1, 1, 0};
    int exp4[13]  = '{4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 0};
    int exp5[5]   = '{3, 4, 5, 0, 1};

    initial begin
        int hi;
        int npe;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_cnt", cnt, 0);
        check("rst_pwm", pwm, 0);
        check("rst_pe", pe, 0);
        check("rst_ack", upd_ack, 0);
        rst_n = 1'b1;
        tick();
        check("idle_cnt", cnt, 0);
        check("idle_pe", pe, 0);

        // 1: UP, per=4, cmp0=2.
        mode = 2'b00; per = 4; set_cmp(2, 0, 0, 4); en = 1'b1; upd_req = 1'b1;
        wait_ack("t1_ack");
        check("t1_cnt_at_ack", cnt, 0);
        hi = 0; npe = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t1_cnt", cnt, exp1[k]);
            hi  += int'(pwm[0]);
            npe += int'(pe);
        end
        check("t1_pwm0_high", hi, 2);
        check("t1_pe_count", npe, 1);

        // 2: DOWN, per=3, channel 1 inverted with compare 0.
        mode = 2'b01; per = 3; pol[1] = 1'b1; upd_req = 1'b1;
        wait_ack("t2_ack");
        check("t2_cnt_at_ack", cnt, 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_cnt", cnt, exp2[k]);
            check("t2_pe", pe, exp2pe[k]);
            check("t2_pwm1", pwm[1], 1);
        end

        // 3: UPDN, per=3, cmp0=2.
        mode = 2'b10; per = 3; set_cmp(2, 0, 0, 4); upd_req = 1'b1;
        wait_ack("t3_ack");
        check("t3_cnt_at_ack", cnt, 1);
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t3_cnt", cnt, exp3[k]);
            check("t3_dir", dir, exp3d[k]);
            hi += int'(pwm[0]);
        end
        check("t3_pwm0_high", hi, 3);

        // 4: UP per=9, request per=5 mid-period.
        mode = 2'b00; per = 9; upd_req = 1'b1;
        wait_ack("t4_ack9");
        wait_cnt(3, "t4_reach3");
        per = 5; upd_req = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            upd_req = 1'b0;
            check("t4_cnt", cnt, exp4[k]);
            check("t4_ack", upd_ack, (k == 6) ? 1 : 0);
        end

        // 5: hold at cnt=2 with a request arriving during the hold.
        wait_cnt(2, "t5_reach2");
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_hold_cnt", cnt, 2);
            check("t5_hold_pe", pe, 0);
            check("t5_hold_ack", upd_ack, 0);
            if (k == 1) begin
                per = 7; upd_req = 1'b1;
            end
            if (k == 2) upd_req = 1'b0;
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_cnt", cnt, exp5[k]);
            check("t5_ack", upd_ack, (k == 3) ? 1 : 0);
        end

        // 6: cmp0 = per+1 gives 100%, cmp2 = 0 gives 0%, then async reset.
        mode = 2'b00; per = 5; set_cmp(6, 0, 0, 4); upd_req = 1'b1;
        wait_ack("t6_ack");
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t6_pwm0_full", pwm[0], 1);
            check("t6_pwm2_zero", pwm[2], 0);
        end
        wait_cnt(3, "t6_reach3");
        en = 1'b0; upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        check("t6_pre_rst_cnt", cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cnt", cnt, 0);
        check("t6_rst_pwm", pwm, 0);
        check("t6_rst_pe", pe, 0);
        check("t6_rst_ack", upd_ack, 0);
        check("t6_rst_dir", dir, 0);
        tick();
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_post_cnt", cnt, 0);
            check("t6_post_pe", pe, 1);
            check("t6_post_ack", upd_ack, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pwm_multi
